eq_i2s_tx: RTL and testbench
============================

EQ_I2S_TX -- requirements
Module: eq_i2s_tx

Interface
REQ-001 Parameter: DEPTH, default 4, sample FIFO depth (power of two, >=2).
REQ-002 Parameter: CLK_DIV, default 4, clk cycles per bclk half-period (>=1).
REQ-003 Port: clk  in  1  single system clock; all state is updated on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: y_in  in  16  signed equalizer output sample, two's complement.
REQ-006 Port: y_valid  in  1  y_in is valid this cycle.
REQ-007 Port: y_ready  out  1  FIFO can accept a sample.
REQ-008 Port: bclk  out  1  I2S bit clock.
REQ-009 Port: lrck  out  1  I2S word select; 0 = left, 1 = right.
REQ-010 Port: sdata  out  1  I2S serial data, MSB first.
REQ-011 Port: fifo_level  out  $clog2(DEPTH)+1  number of samples held in the FIFO.
REQ-012 Port: underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.

Function
REQ-013 y_ready SHALL equal (fifo_level < DEPTH), combinationally.
REQ-014 Push: y_valid && y_ready at a clk edge SHALL write y_in to the FIFO tail, FIFO order.
REQ-015 A push while full SHALL be dropped, even if a pop occurs in the same cycle; no bypass path exists.
REQ-016 Simultaneous push and pop with 0 < level < DEPTH SHALL leave fifo_level unchanged.
REQ-017 FIFO pointers SHALL wrap modulo DEPTH.
REQ-018 Divider: div_cnt SHALL count 0..CLK_DIV-1; at CLK_DIV-1 it SHALL reset to 0 and bclk SHALL toggle.
REQ-019 bit_cnt (0..31) SHALL advance by 1, wrapping 31->0, on every clk edge where bclk toggles 1->0 (bclk falling edge).
REQ-020 lrck SHALL be 0 while bit_cnt is 0..15 and 1 while bit_cnt is 16..31; lrck is registered and changes with bit_cnt.
REQ-021 Frame start is the bclk falling edge on which bit_cnt goes 0->1.
REQ-022 At frame start, the block SHALL pop the FIFO head S, load a 32-bit shift register with {S,S}, and drive sdata with bit 31.
REQ-023 On each later bclk falling edge, the shift register SHALL shift left and sdata SHALL take the new bit 31.
REQ-024 Result: left-word MSB..LSB appears at bit_cnt 1..16, right-word MSB..LSB at bit_cnt 17..31,0, which is the standard one-bclk I2S delay.
REQ-025 Mono: the same sample SHALL be sent on both channels, with no change to its value or sign.
REQ-026 If the FIFO is empty at frame start, the shift register SHALL load 0.
REQ-027 In that empty case, underrun SHALL pulse high for exactly that one clk cycle and no pop SHALL occur.
REQ-028 Changes to sdata and lrck SHALL occur only on bclk falling edges; both are stable across every bclk rising edge.
REQ-029 One frame SHALL take 64*CLK_DIV clk cycles; output sample rate = f_clk/(64*CLK_DIV).
REQ-030 Latency: a sample pushed into an empty FIFO SHALL appear at the next frame start.

Reset
REQ-031 rst_n low SHALL immediately, asynchronously, set: bclk=0, lrck=0, sdata=0, underrun=0; div_cnt, bit_cnt, shift register and pointers to 0.
REQ-032 Consequence of REQ-031: fifo_level=0 and y_ready=1 while in reset.
REQ-033 Reset asserted mid-frame SHALL discard FIFO contents and the partial word.
REQ-034 After rst_n rises, the first bclk rising edge SHALL come CLK_DIV cycles later.
REQ-035 After rst_n rises, the first frame start SHALL come 2*CLK_DIV cycles later.

Verification (CLK_DIV=2, DEPTH=4)
REQ-036 Reset: hold rst_n=0 -> bclk/lrck/sdata/underrun=0, fifo_level=0, y_ready=1; release -> bclk period = 4 clk.
REQ-037 Single sample: push 16'h8001 before first frame start -> left serial bits at bit_cnt 1..16 = 1000_0000_0000_0001 with lrck 0 for bit_cnt 1..15, lrck 1 at bit_cnt 16; right identical at bit_cnt 17..31,0; fifo_level returns 0.
REQ-038 Underrun: no pushes -> sdata=0 throughout; underrun exactly one 1-cycle pulse per 128-clk frame; fifo_level stays 0.
REQ-039 Full FIFO: push 16'h0001..16'h0005 on consecutive cycles after reset -> first four accepted, y_ready=0 after fourth, fifo_level=4, 16'h0005 lost; frames then emit 0001,0002,0003,0004 in order.
REQ-040 Mid-frame reset: push 16'hFFFF, pulse rst_n low at bit_cnt 8 -> outputs 0 asynchronously, fifo_level=0, next frame sends zeros with underrun.
REQ-041 Simultaneous push/pop: level=1, push coincident with frame-start pop -> fifo_level stays 1, sample order preserved.

Source files
------------

// File: rtl/eq_i2s_tx.sv
// Mono I2S transmitter: buffers signed equalizer samples in a small FIFO and
// serialises each one onto both I2S channels, MSB first, with the one-bclk delay.
module eq_i2s_tx #(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              y_in,
    input  logic                     y_valid,
    output logic                     y_ready,
    output logic                     bclk,
    output logic                     lrck,
    output logic                     sdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    logic signed [15:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [DW-1:0]      div_cnt;
    logic [4:0]         bit_cnt;
    logic [4:0]         bit_cnt_nxt;
    logic [31:0]        shreg;
    logic signed [15:0] head;
    logic               div_wrap;
    logic               bclk_fall;
    logic               frame_start;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign y_ready     = (fifo_level < FULL_LVL);
    assign fifo_empty  = (fifo_level == '0);
    assign div_wrap    = (div_cnt == DIV_MAX);
    assign bclk_fall   = div_wrap && bclk;
    assign frame_start = bclk_fall && (bit_cnt == 5'd0);
    assign bit_cnt_nxt = bit_cnt + 5'd1;
    assign push        = y_valid && y_ready;
    assign pop         = frame_start && !fifo_empty;
    assign head        = mem[rd_ptr];
    assign sdata       = shreg[31];

    // Sample storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= $signed(y_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Bit clock divider and frame position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
            lrck    <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (bclk_fall) begin
                bit_cnt <= bit_cnt_nxt;
                lrck    <= bit_cnt_nxt[4];
            end
        end
    end

    // Serialiser: {S,S} puts the left word at bit_cnt 1..16 and the right at 17..31,0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_start && fifo_empty;
            if (frame_start) begin
                shreg <= pop ? {head, head} : 32'd0;
            end else if (bclk_fall) begin
                shreg <= {shreg[30:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_eq_i2s_tx.sv
// Self-checking bench for eq_i2s_tx (DEPTH=4, CLK_DIV=2) against a time-based
// reference model: FIFO as a queue, I2S outputs derived from the clock count.
module tb_eq_i2s_tx;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 2;
    localparam int FP      = 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] y_in = '0;
    logic        y_valid = 1'b0;
    logic        y_ready;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic [7:0]  obs;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          n;
    logic [15:0] mq [$];
    logic [15:0] cur_word;
    logic        m_under;

    eq_i2s_tx #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
        .bclk(bclk), .lrck(lrck), .sdata(sdata), .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    assign obs = {bclk, lrck, sdata, underrun, y_ready, fifo_level};

    // Expected outputs after n clk edges since reset release
    function automatic logic [7:0] exp_vec();
        int          f;
        int          k;
        logic [31:0] w;
        logic        sd;
        logic        bc;
        logic        lr;
        f  = n / FP;
        w  = {cur_word, cur_word};
        sd = 1'b0;
        if (f > 0) begin
            k  = (f - 1) % 32;
            sd = w[31 - k];
        end
        bc = ((n / CLK_DIV) % 2) == 1;
        lr = (f % 32) >= 16;
        return {bc, lr, sd, m_under, (mq.size() < DEPTH), 3'(mq.size())};
    endfunction

    task automatic model_reset();
        mq.delete();
        n = 0;
        cur_word = '0;
        m_under = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model, return at the next negedge.
    task automatic tick(input logic v, input logic [15:0] d);
        logic fs;
        logic pu;
        logic po;
        y_valid = v;
        y_in    = d;
        fs = (((n + 1) % FP) == 0) && ((((n + 1) / FP) % 32) == 1);
        pu = v && (mq.size() < DEPTH);
        po = fs && (mq.size() > 0);
        m_under = fs && !po;
        if (fs) cur_word = po ? mq[0] : 16'h0000;
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back(d);
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        y_valid = 1'b0;
        y_in = '0;
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int   rise [$];
        logic prev;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            y_valid = 1'b1;
            y_in = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (obs !== 8'b0000_1000) begin
                n_fail++;
                $display("FAIL reset_hold got=%b exp=%b", obs, 8'b0000_1000);
            end
        end
        y_valid = 1'b0;
        model_reset();
        rst_n = 1'b1;
        prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 16'h0);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_release n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
            if (bclk && !prev) rise.push_back(n);
            prev = bclk;
        end
        n_tests++;
        if (rise.size() < 2 || rise[0] != CLK_DIV || (rise[1] - rise[0]) != FP) begin
            n_fail++;
            $display("FAIL bclk_period rises=%p exp first=%0d period=%0d", rise, CLK_DIV, FP);
        end
    endtask

    task automatic test_single();
        logic [15:0] left;
        logic [15:0] right;
        int          f;
        do_reset();
        left = '0;
        right = '0;
        while (n < 134) begin
            tick(n == 0, 16'h8001);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL single n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
            f = n / FP;
            if ((n % FP) == CLK_DIV) begin
                if (f >= 1 && f <= 16) left = {left[14:0], sdata};
                if (f >= 17 && f <= 32) right = {right[14:0], sdata};
            end
        end
        n_tests++;
        if (left !== 16'h8001 || right !== 16'h8001 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL single_word left=%h right=%h level=%0d exp 8001/8001/0", left, right, fifo_level);
        end
    endtask

    task automatic test_underrun();
        int pulses;
        int ones;
        do_reset();
        pulses = 0;
        ones = 0;
        while (n < 259) begin
            tick(1'b0, 16'h0);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL underrun n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
            if (underrun === 1'b1) pulses++;
            if (sdata !== 1'b0) ones++;
        end
        n_tests++;
        if (pulses != 2 || ones != 0) begin
            n_fail++;
            $display("FAIL underrun_count pulses=%0d sdata_ones=%0d exp 2/0", pulses, ones);
        end
    endtask

    task automatic test_full();
        logic [15:0] sh;
        logic [15:0] got [$];
        logic        v;
        logic [15:0] d;
        int          f;
        do_reset();
        sh = '0;
        while (n < 580) begin
            v = ((n + 1 >= 11) && (n + 1 <= 15)) || (n + 1 == 132);
            d = (n + 1 <= 15) ? 16'(n - 9) : 16'h0009;
            tick(v, d);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL full n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
            if (n == 14 || n == 15) begin
                n_tests++;
                if (y_ready !== 1'b0 || fifo_level !== 3'd4) begin
                    n_fail++;
                    $display("FAIL full_level n=%0d ready=%b level=%0d exp 0/4", n, y_ready, fifo_level);
                end
            end
            f = n / FP;
            if ((n % FP) == CLK_DIV && f > 32 && (f % 32) >= 1 && (f % 32) <= 16) begin
                sh = {sh[14:0], sdata};
                if ((f % 32) == 16) got.push_back(sh);
            end
        end
        n_tests++;
        if (got.size() != 4 || got[0] !== 16'h0001 || got[1] !== 16'h0002 ||
            got[2] !== 16'h0003 || got[3] !== 16'h0004) begin
            n_fail++;
            $display("FAIL full_order got=%p exp 0001 0002 0003 0004", got);
        end
    endtask

    task automatic test_midframe_reset();
        int pulses;
        int ones;
        do_reset();
        while (n < 34) begin
            tick(n < 2, 16'hFFFF);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL midframe n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL midframe_async got=%b exp=%b", obs, 8'b0000_1000);
        end
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        pulses = 0;
        ones = 0;
        while (n < 133) begin
            tick(1'b0, 16'h0);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL midframe_after n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
            if (underrun === 1'b1) pulses++;
            if (sdata !== 1'b0) ones++;
        end
        n_tests++;
        if (pulses != 2 || ones != 0) begin
            n_fail++;
            $display("FAIL midframe_zeros pulses=%0d sdata_ones=%0d exp 2/0", pulses, ones);
        end
    endtask

    task automatic test_simul_push_pop();
        logic [15:0] sh;
        logic [15:0] got [$];
        logic        v;
        logic [15:0] d;
        int          f;
        do_reset();
        sh = '0;
        while (n < 324) begin
            v = (n + 1 == 1) || (n + 1 == 10) || (n + 1 == 132);
            d = (n + 1 == 1) ? 16'h1234 : (n + 1 == 10) ? 16'hBEEF : 16'h8000;
            tick(v, d);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL simul n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
            if (n == 132) begin
                n_tests++;
                if (fifo_level !== 3'd1) begin
                    n_fail++;
                    $display("FAIL simul_level got=%0d exp=1", fifo_level);
                end
            end
            f = n / FP;
            if ((n % FP) == CLK_DIV && (f % 32) >= 1 && (f % 32) <= 16) begin
                sh = {sh[14:0], sdata};
                if ((f % 32) == 16) got.push_back(sh);
            end
        end
        n_tests++;
        if (got.size() != 3 || got[0] !== 16'h1234 || got[1] !== 16'hBEEF || got[2] !== 16'h8000) begin
            n_fail++;
            $display("FAIL simul_order got=%p exp 1234 beef 8000", got);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            tick($urandom_range(0, 39) == 0, 16'($urandom));
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random n=%0d got=%b exp=%b", n, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_underrun();
        test_full();
        test_midframe_reset();
        test_simul_push_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
